// File: rtl/smc_pkg.sv
// Shared types and constants for the SuperMOSFET sequencer: FSM states,
// datapath sizing, accumulation weights and mode bit positions.
package smc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        ACC,
        OUT
    } state_t;

    localparam int VAL_W = 10;
    localparam int N_TR  = 6;

    localparam int WGT_0 = 3;
    localparam int WGT_1 = 4;
    localparam int WGT_2 = 5;

    localparam int MODE_ID_BIT  = 0;
    localparam int MODE_MAX_BIT = 1;

endpackage

// File: rtl/smc_seq_ctrl_if.sv
// Beat-input / result-output handshake bundle between the host and the sequencer.
interface smc_seq_ctrl_if #(
    parameter int VAL_W = 10
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       W;
    logic [2:0]       V_GS;
    logic [2:0]       V_DS;
    logic [1:0]       mode;
    logic             out_valid;
    logic             out_ready;
    logic [VAL_W-1:0] out_n;

    modport master (
        output in_valid, W, V_GS, V_DS, mode, out_ready,
        input  in_ready, out_valid, out_n
    );

    modport slave (
        input  in_valid, W, V_GS, V_DS, mode, out_ready,
        output in_ready, out_valid, out_n
    );
endinterface

// File: rtl/smc_id_gm_unit.sv
// Combinational drain-current / transconductance evaluator for one transistor
// beat; all intermediates are unsigned 12-bit and the divide-by-3 floors last.
module smc_id_gm_unit #(
    parameter int VAL_W = 10
) (
    input  logic [2:0]       W,
    input  logic [2:0]       V_GS,
    input  logic [2:0]       V_DS,
    input  logic             id_sel,
    output logic [VAL_W-1:0] value
);

    logic [11:0] w_x;
    logic [11:0] t_x;
    logic [11:0] v_x;
    logic [11:0] prod;
    logic [11:0] quo;
    logic        triode;

    always_comb begin
        w_x    = {9'd0, W};
        v_x    = {9'd0, V_DS};
        t_x    = {9'd0, V_GS} - 12'd1;
        triode = (t_x > v_x);
        prod   = '0;
        // V_GS=0 wraps t_x; cutoff forces zero before it can be used
        if (V_GS == 3'd0) begin
            prod = '0;
        end else if (id_sel) begin
            prod = triode ? w_x * (((t_x * v_x) << 1) - (v_x * v_x))
                          : w_x * t_x * t_x;
        end else begin
            prod = triode ? (w_x * v_x) << 1
                          : (w_x * t_x) << 1;
        end
        quo   = prod / 12'd3;
        value = quo[VAL_W-1:0];
    end

endmodule

// File: rtl/smc_seq_ctrl.sv
// Time-multiplexed SuperMOSFET sequencer: evaluates six beats on one shared
// unit, keeps them in a descending insertion-sorted buffer, then accumulates.
module smc_seq_ctrl #(
    parameter int VAL_W = smc_pkg::VAL_W,
    parameter int N_TR  = smc_pkg::N_TR
) (
    input logic           clk,
    input logic           rst_n,
    smc_seq_ctrl_if.slave bus
);
    import smc_pkg::*;

    typedef logic [N_TR-1:0][VAL_W-1:0] buf_t;

    state_t           state;
    state_t           state_nxt;
    logic [2:0]       cnt;
    logic [1:0]       mode_q;
    logic [1:0]       idx;
    buf_t             sort_buf;
    logic [VAL_W-1:0] acc;
    logic [VAL_W-1:0] unit_val;
    logic [VAL_W-1:0] term;
    logic [2:0]       sel;
    logic             id_sel;
    logic             in_ready_i;
    logic             accept;

    // Entries strictly smaller than v shift down; equal ones stay ahead of v.
    function automatic buf_t sort_insert(input buf_t b, input logic [VAL_W-1:0] v);
        buf_t r;
        r[0] = (b[0] >= v) ? b[0] : v;
        for (int i = 1; i < N_TR; i++) begin
            if (b[i] >= v)        r[i] = b[i];
            else if (b[i-1] >= v) r[i] = v;
            else                  r[i] = b[i-1];
        end
        return r;
    endfunction

    function automatic logic [2:0] weight_of(input logic [1:0] i, input logic id_mode);
        if (!id_mode)     return 3'd1;
        else if (i == 0)  return 3'(WGT_0);
        else if (i == 1)  return 3'(WGT_1);
        else              return 3'(WGT_2);
    endfunction

    function automatic logic [VAL_W-1:0] weighted(input logic [VAL_W-1:0] e, input logic [2:0] w);
        return e * {{(VAL_W-3){1'b0}}, w};
    endfunction

    // Beat 0 evaluates against the live mode; later beats use the latched copy.
    assign id_sel = (state == IDLE) ? bus.mode[MODE_ID_BIT] : mode_q[MODE_ID_BIT];

    smc_id_gm_unit #(.VAL_W(VAL_W)) u_unit (
        .W      (bus.W),
        .V_GS   (bus.V_GS),
        .V_DS   (bus.V_DS),
        .id_sel (id_sel),
        .value  (unit_val)
    );

    assign in_ready_i   = rst_n && ((state == IDLE) || (state == LOAD));
    assign bus.in_ready = in_ready_i;
    assign accept       = bus.in_valid && in_ready_i;
    assign bus.out_n    = acc;

    assign sel  = mode_q[MODE_MAX_BIT] ? {1'b0, idx} : ({1'b0, idx} + 3'd3);
    assign term = weighted(sort_buf[sel], weight_of(idx, mode_q[MODE_ID_BIT]));

    always_comb begin
        state_nxt     = state;
        bus.out_valid = 1'b0;
        case (state)
            IDLE: if (accept) state_nxt = LOAD;
            LOAD: if (accept && (cnt == 3'd5)) state_nxt = ACC;
            ACC:  if (idx == 2'd2) state_nxt = OUT;
            OUT: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            mode_q   <= '0;
            idx      <= '0;
            sort_buf <= '0;
            acc      <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                sort_buf <= sort_insert(sort_buf, unit_val);
                cnt      <= (state == IDLE) ? 3'd1 : cnt + 3'd1;
            end
            if (accept && (state == IDLE)) mode_q <= bus.mode;
            if (state == ACC) begin
                idx <= idx + 2'd1;
                acc <= (idx == 2'd0) ? term : acc + term;
            end else begin
                idx <= '0;
            end
            if ((state == OUT) && bus.out_ready) begin
                sort_buf <= '0;
                cnt      <= '0;
            end
        end
    end

endmodule

// File: tb/tb_smc_seq_ctrl.sv
// Scoreboard bench for smc_seq_ctrl: jobs push their hand-computed result,
// a negedge monitor pops and compares on every output handshake.
module tb_smc_seq_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_q[$];
    int   bw[6];
    int   bg[6];
    int   bd[6];

    smc_seq_ctrl_if #(.VAL_W(10)) bus ();

    smc_seq_ctrl #(.VAL_W(10), .N_TR(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: output handshakes against the scoreboard, plus ready/valid exclusion.
    always @(negedge clk) begin
        if (rst_n) begin
            check("ready_valid_excl", int'(bus.in_ready && bus.out_valid), 0);
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", int'(bus.out_n), -1);
                end else begin
                    check("out_n", int'(bus.out_n), exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic load_set(input int s);
        for (int i = 0; i < 6; i++) begin
            case (s)
                0: begin bw[i] = 3;     bg[i] = 3; bd[i] = 1; end
                1: begin bw[i] = i + 1; bg[i] = 7; bd[i] = 7; end
                2: begin bw[i] = 7;     bg[i] = 7; bd[i] = 7; end
                default: ;
            endcase
        end
        if (s == 3) begin
            bw = '{5, 7, 3, 2, 4, 6};
            bg = '{6, 0, 3, 4, 2, 5};
            bd = '{2, 3, 1, 3, 1, 1};
        end
    endtask

    task automatic send_beat(input int w, input int g, input int d, input logic [1:0] m);
        bit rdy;
        int n;
        n = 0;
        bus.W        = 3'(w);
        bus.V_GS     = 3'(g);
        bus.V_DS     = 3'(d);
        bus.mode     = m;
        bus.in_valid = 1'b1;
        do begin
            @(negedge clk);
            rdy = bus.in_ready;
            @(posedge clk);
            n++;
        end while (!rdy && n < 50);
        if (!rdy) check("beat_accept", 0, 1);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic run_job(input logic [1:0] md, input int exp, input int gap,
                           input bit toggle, input bit stall);
        int k;
        logic [1:0] m;
        exp_q.push_back(exp);
        bus.out_ready = !stall;
        for (int i = 0; i < 6; i++) begin
            m = (toggle && i > 0) ? ~md : md;
            send_beat(bw[i], bg[i], bd[i], m);
            if (i < 5 && gap > 0) begin
                repeat (gap) @(posedge clk);
                #1;
            end
        end
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.out_valid && k < 10);
        check("latency", k, 4);
        if (stall) begin
            repeat (5) begin
                check("stall_out_valid", int'(bus.out_valid), 1);
                check("stall_out_n", int'(bus.out_n), exp);
                check("stall_in_ready", int'(bus.in_ready), 0);
                @(negedge clk);
            end
            @(posedge clk);
            #1 bus.out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        check("post_in_ready", int'(bus.in_ready), 1);
        check("post_out_valid", int'(bus.out_valid), 0);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.W         = '0;
        bus.V_GS      = '0;
        bus.V_DS      = '0;
        bus.mode      = '0;
        bus.out_ready = 1'b1;
        #2;
        check("rst_in_ready", int'(bus.in_ready), 0);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_out_n", int'(bus.out_n), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_in_ready", int'(bus.in_ready), 1);

        load_set(0);
        run_job(2'b01, 36, 0, 0, 0);
        run_job(2'b00, 6, 0, 0, 0);
        load_set(1);
        run_job(2'b11, 696, 0, 0, 0);
        run_job(2'b01, 264, 0, 0, 0);
        // mixed triode/saturation/cutoff: ID 26,0,3,6,1,14  gm 6,0,2,4,2,4
        load_set(3);
        run_job(2'b11, 164, 0, 0, 0);
        run_job(2'b01, 13, 0, 0, 0);
        run_job(2'b10, 14, 0, 0, 0);
        run_job(2'b00, 4, 0, 0, 0);
        load_set(2);
        run_job(2'b11, 1008, 0, 0, 0);
        load_set(0);
        run_job(2'b01, 36, 0, 0, 1);

        // abort a job part-way; stale 84s would show up in a largest-three sum
        load_set(2);
        for (int i = 0; i < 3; i++) send_beat(bw[i], bg[i], bd[i], 2'b11);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", int'(bus.out_valid), 0);
        check("async_rst_out_n", int'(bus.out_n), 0);
        check("async_rst_in_ready", int'(bus.in_ready), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rerst_in_ready", int'(bus.in_ready), 1);
        load_set(0);
        run_job(2'b11, 36, 0, 0, 0);

        load_set(1);
        run_job(2'b11, 696, 2, 1, 0);

        repeat (4) @(posedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/smc_seq_ctrl.md
Name: smc_seq_ctrl

Overview:
- Time-multiplexed sequencer for the SuperMOSFET calculator: accepts six transistor parameter sets one beat at a time and evaluates each beat on a single shared ID/gm unit as it arrives.
- Keeps a running descending-sorted 6-entry buffer, then computes the mode-selected three-term sum over three cycles and returns it through a valid/ready output handshake.
- Sits between the stimulus/host interface and downstream result consumers; it replaces six parallel calc units and a combinational sorting network.

Parameters:
- VAL_W, 10, width of per-transistor result, sort entries and out_n
- N_TR, 6, transistors per job (fixed; N_TR other than 6 not supported)

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  beat valid
- in_ready  output  1  controller can accept a beat
- W  input  3  channel width of this beat
- V_GS  input  3  gate-source voltage of this beat
- V_DS  input  3  drain-source voltage of this beat
- mode  input  2  [0]=1 ID / 0 gm; [1]=1 largest three / 0 smallest three; sampled on beat 0 only
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_n  output  10  result

Behaviour:
- Clock and reset are decided: one clock clk; reset rst_n is asynchronous, active-low.
- Reset: state=IDLE, beat count=0, sort buffer=0, accumulator=0, in_ready=0 during reset then 1 after, out_valid=0, out_n=0. Reset mid-job discards all partial data.
- A beat is accepted on a clk edge where in_valid && in_ready.
- Beats may have gaps; in_valid is ignored while in_ready=0.
- States:
  - IDLE: in_ready=1. Accepting a beat latches mode, stores the beat, count=1, goes to LOAD.
  - LOAD: in_ready=1. Each accepted beat increments count. Accepting the beat with count=5 goes to ACC with idx=0.
  - ACC: in_ready=0. One multiply-add per cycle, idx 0..2. After idx=2, goes to OUT.
  - OUT: in_ready=0, out_valid=1, out_n holds the sum. On out_ready=1, goes to IDLE, out_valid=0, buffer cleared.
- Latency: if beat 5 is accepted at edge E, out_valid is 1 after edge E+3.
- out_n and out_valid stay stable while out_ready=0.
- in_ready and out_valid are never both 1.
- Unit arithmetic (combinational, per beat), with t = V_GS-1:
  - Triode if t > V_DS, else saturation.
  - ID triode = floor(W*(2*t*V_DS - V_DS^2)/3); ID saturation = floor(W*t*t/3).
  - gm triode = floor(2*W*V_DS/3); gm saturation = floor(2*W*t/3).
  - V_GS=0 means t<0: treat as cutoff, result 0.
  - Evaluate in unsigned 10-bit or wider intermediates; floor only after the product.
- Sort buffer: descending, entries 0..5. Each new value is inserted in one cycle: entries smaller than it shift down. Ties insert after existing equal values.
- Selection: mode[1]=1 uses entries 0,1,2; mode[1]=0 uses entries 3,4,5.
- Weights: for ID (mode[0]=1), idx0*3 + idx1*4 + idx2*5; for gm, the plain sum.
- Max result 84*12=1008 fits in 10 bits; no saturation logic needed.

Decomposition:
- Package smc_pkg: state enum (IDLE, LOAD, ACC, OUT), VAL_W, N_TR, weight constants 3/4/5, mode bit indices.
- Sub-module smc_id_gm_unit: combinational W/V_GS/V_DS/mode[0] to 10-bit value.
- Sorting and accumulation stay in the top.

Test Plan:
- Six beats W=3,V_GS=3,V_DS=1, mode=01 -> out_n=36. Same beats with mode=00 -> out_n=6.
- Beats W=1..6, V_GS=7, V_DS=7, mode=11 -> values 12..72; out_n=72*3+60*4+48*5=696. Same beats with mode=01 -> 36*3+24*4+12*5=264.
- All beats W=7,V_GS=7,V_DS=7, mode=11 -> out_n=1008. out_valid rises exactly 3 edges after beat 5 is accepted.
- out_ready=0 for 5 cycles in OUT -> out_valid=1, out_n stable, in_ready=0. Then out_ready=1 -> next cycle IDLE with in_ready=1.
- rst_n pulsed low after 3 beats -> out_valid=0, out_n=0 asynchronously. The next 6 beats from the first test -> 36 (no stale data).
- in_valid gaps of 2 cycles between beats, plus mode toggled on beats 1..5 -> result uses the beat-0 mode only; matches the gap-free run.
